muller_c_pipeline: RTL

- Parametrised, clock-synchronous model of a Muller C-element micropipeline: DEPTH chained C-element stages carrying WIDTH-bit bundled data under a two-phase (transition) req/ack handshake.
- Successor to the single C-element project. Generalises the C-element into a configurable-depth, configurable-width token pipeline with occupancy reporting and protocol-violation detection.
- Sits between the io_in/io_out pad logic and the formal/cover harness.

---
 rtl/muller_c_pipeline.sv | 103 ++++++++++
 1 files changed

// File: rtl/muller_c_pipeline.sv
// Clock-synchronous Muller C-element micropipeline: DEPTH stages of two-phase
// req/ack handshaking carrying WIDTH-bit bundled data, with occupancy and protocol checks.
module muller_c_pipeline #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         in_req,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ack,
    output logic                         out_req,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ack,
    output logic [DEPTH-1:0]             c_state,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         proto_err
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             in_req_q, in_req_d;
    logic             out_ack_q, out_ack_d;
    logic             proto_err_q, proto_err_d;

    logic [DEPTH-1:0] a_vec;
    logic [DEPTH-1:0] b_vec;
    logic [DEPTH-1:0] next_vec;
    logic [DEPTH-1:0] held;
    logic [WIDTH-1:0] d_src [DEPTH];
    logic [OCC_W-1:0] occ_sum;
    logic             in_err;
    logic             out_err;

    // Neighbour views of the chain built as shifted vectors so every stage sees only pre-edge state.
    always_comb begin
        a_vec    = {c_q[DEPTH-2:0], in_req};
        next_vec = {out_ack, c_q[DEPTH-1:1]};
        b_vec    = ~next_vec;
        held     = c_q ^ next_vec;

        d_src[0] = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            d_src[i] = d_q[i-1];
        end

        c_d = c_q;
        d_d = d_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a_vec[i] == b_vec[i]) begin
                c_d[i] = a_vec[i];
            end
            if (c_d[i] != c_q[i]) begin
                d_d[i] = d_src[i];
            end
        end

        occ_sum = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(held[i]);
        end
    end

    // Sender toggling before its last request was acknowledged, or consumer acking nothing.
    always_comb begin
        in_err      = (in_req != in_req_q) && (in_req_q != c_q[0]);
        out_err     = (out_ack != out_ack_q) && (c_q[DEPTH-1] == out_ack_q);
        in_req_d    = in_req;
        out_ack_d   = out_ack;
        proto_err_d = proto_err_q | in_err | out_err;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            c_q         <= '0;
            in_req_q    <= 1'b0;
            out_ack_q   <= 1'b0;
            proto_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            c_q         <= c_d;
            in_req_q    <= in_req_d;
            out_ack_q   <= out_ack_d;
            proto_err_q <= proto_err_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_ack    = c_q[0];
    assign out_req   = c_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign c_state   = c_q;
    assign occupancy = occ_sum;
    assign proto_err = proto_err_q;

endmodule
